// File: rtl/mem_bus_arbiter.sv
// Shares one 64-bit memory bus between instruction fetch and data access.
// Data has priority, fetch gets a forced grant after a bounded data streak.
//
// state   | meaning
// IDLE    | no transfer; selects the next grant
// IF_XFER | fetch transfer on the bus, waiting for ack or timeout
// DM_XFER | data transfer on the bus, waiting for ack or timeout
// RESP    | one-cycle ready pulse to the granted requester
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_DM_STREAK  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        dm_req,
    input  logic        dm_rw,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_ready,
    output logic [63:0] dm_rdata,
    output logic        bus_req,
    output logic        bus_rw,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [63:0] bus_rdata,
    output logic        bus_err,
    output logic        if_stall,
    output logic        dm_stall
);

    typedef enum logic [1:0] {IDLE, IF_XFER, DM_XFER, RESP} state_t;

    localparam logic [3:0]  STREAK_MAX = 4'(MAX_DM_STREAK);
    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  streak_q;
    logic [15:0] wait_q;
    logic        addr2_q;
    logic        rw_q;
    logic        grant_dm, grant_if, ack_done, timed_out;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        ack_done  = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req && !(if_req && streak_q == STREAK_MAX)) begin
                    grant_dm = 1'b1;
                    state_d  = DM_XFER;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_d  = IF_XFER;
                end
            end
            IF_XFER, DM_XFER: begin
                if (bus_ack) begin
                    ack_done = 1'b1;
                    state_d  = RESP;
                end else if (wait_q == WAIT_LAST) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q  <= '0;
            wait_q    <= '0;
            addr2_q   <= 1'b0;
            rw_q      <= 1'b0;
            bus_req   <= 1'b0;
            bus_rw    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            bus_err   <= 1'b0;
            if_data   <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            bus_err  <= 1'b0;

            if (grant_dm) begin
                bus_req   <= 1'b1;
                bus_rw    <= dm_rw;
                bus_addr  <= dm_addr;
                bus_wdata <= dm_wdata;
                rw_q      <= dm_rw;
                wait_q    <= '0;
                if (!if_req)                    streak_q <= '0;
                else if (streak_q != STREAK_MAX) streak_q <= streak_q + 4'd1;
            end

            if (grant_if) begin
                bus_req   <= 1'b1;
                bus_rw    <= 1'b0;
                bus_addr  <= if_addr;
                bus_wdata <= '0;
                addr2_q   <= if_addr[2];
                wait_q    <= '0;
                streak_q  <= '0;
            end

            if (state_q == IF_XFER || state_q == DM_XFER) wait_q <= wait_q + 16'd1;

            // Timeout completes like an ack but with zeroed data and an error pulse.
            if (ack_done || timed_out) begin
                bus_req <= 1'b0;
                bus_err <= timed_out;
                if (state_q == IF_XFER) begin
                    if_ready <= 1'b1;
                    if (timed_out)    if_data <= '0;
                    else if (addr2_q) if_data <= bus_rdata[63:32];
                    else              if_data <= bus_rdata[31:0];
                end else begin
                    dm_ready <= 1'b1;
                    dm_rdata <= (timed_out || rw_q) ? 64'd0 : bus_rdata;
                end
            end
        end
    end

    assign if_stall = if_req & ~if_ready;
    assign dm_stall = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected grants and responses are
// queued by the stimulus and checked by an independent monitor.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_data;
    logic        dm_req = 1'b0;
    logic        dm_rw = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic        dm_ready;
    logic [63:0] dm_rdata;
    logic        bus_req;
    logic        bus_rw;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [63:0] bus_rdata = '0;
    logic        bus_err;
    logic        if_stall;
    logic        dm_stall;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .MAX_DM_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .dm_req(dm_req), .dm_rw(dm_rw), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .if_stall(if_stall), .dm_stall(dm_stall)
    );

    typedef struct {
        logic [63:0] addr;
        logic        rw;
        logic [63:0] wdata;
        int          busy;
    } grant_t;

    typedef struct {
        logic        is_if;
        logic [63:0] data;
        logic        err;
        int          lat;
    } rsp_t;

    grant_t gq[$];
    rsp_t   rq[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     last_if_cyc = 0;
    int     last_dm_cyc = 0;
    int     ack_wait = 0;
    logic   no_ack = 1'b0;
    int     if_left = 0;
    int     dm_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_grant(logic [63:0] a, logic rw, logic [63:0] wd, int busy);
        grant_t g;
        g.addr = a; g.rw = rw; g.wdata = wd; g.busy = busy;
        gq.push_back(g);
    endtask

    task automatic push_rsp(logic is_if, logic [63:0] d, logic err, int lat);
        rsp_t r;
        r.is_if = is_if; r.data = d; r.err = err; r.lat = lat;
        rq.push_back(r);
    endtask

    // Bus slave: acks after ack_wait cycles of bus_req, or never when no_ack.
    initial begin
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1 && !no_ack) begin
                bus_ack = (n == ack_wait);
                n++;
            end else begin
                bus_ack = 1'b0;
                n = 0;
            end
        end
    end

    // Monitor
    initial begin
        logic        prev;
        int          hi;
        int          gcyc;
        logic [63:0] a_hold;
        logic [63:0] w_hold;
        grant_t      g;
        rsp_t        r;
        logic [63:0] got;
        prev = 1'b0; hi = 0; gcyc = 0; a_hold = '0; w_hold = '0;
        g.addr = '0; g.rw = 1'b0; g.wdata = '0; g.busy = 0;
        forever begin
            @(negedge clk);
            check("if_stall", if_stall, if_req & ~if_ready);
            check("dm_stall", dm_stall, dm_req & ~dm_ready);
            if (bus_req === 1'b1 && !prev) begin
                check("grant_pending", gq.size() > 0, 1);
                if (gq.size() > 0) g = gq.pop_front();
                check("grant_addr", bus_addr, g.addr);
                check("grant_rw", bus_rw, g.rw);
                check("grant_wdata", bus_wdata, g.wdata);
                hi = 0; gcyc = cyc; a_hold = bus_addr; w_hold = bus_wdata;
            end
            if (bus_req === 1'b1) begin
                hi++;
                check("bus_addr_stable", bus_addr, a_hold);
                check("bus_wdata_stable", bus_wdata, w_hold);
            end
            if (bus_req !== 1'b1 && prev) check("bus_req_len", hi, g.busy);
            if (bus_err === 1'b1) check("bus_err_with_ready", if_ready | dm_ready, 1);
            if (if_ready === 1'b1 || dm_ready === 1'b1) begin
                check("ready_overlap", if_ready & dm_ready, 0);
                check("rsp_pending", rq.size() > 0, 1);
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    got = r.is_if ? {32'd0, if_data} : dm_rdata;
                    check("rsp_kind", if_ready, r.is_if);
                    check("rsp_data", got, r.data);
                    check("rsp_err", bus_err, r.err);
                    check("rsp_latency", cyc - gcyc, r.lat);
                end
                if (if_ready === 1'b1) last_if_cyc = cyc;
                if (dm_ready === 1'b1) last_dm_cyc = cyc;
            end
            prev = (bus_req === 1'b1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Requesters hold req until served the given number of times.
    task automatic serve(int n_if, int n_dm);
        int guard;
        guard = 0;
        if_left = n_if;
        dm_left = n_dm;
        if_req = (n_if > 0);
        dm_req = (n_dm > 0);
        while ((if_left > 0 || dm_left > 0) && guard < 400) begin
            tick();
            guard++;
            if (if_ready && if_left > 0) begin
                if_left--;
                if (if_left == 0) if_req = 1'b0;
            end
            if (dm_ready && dm_left > 0) begin
                dm_left--;
                if (dm_left == 0) dm_req = 1'b0;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        check("serve_in_time", guard < 400, 1);
        tick();
        tick();
    endtask

    initial begin
        repeat (3) tick();
        check("rst_bus_req", bus_req, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_dm_ready", dm_ready, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_if_data", if_data, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        rst = 1'b0;
        tick();

        // single fetch, upper word
        bus_rdata = 64'hAAAAAAAA_BBBBBBBB;
        if_addr = 64'h1004;
        push_grant(64'h1004, 1'b0, 64'd0, 1);
        push_rsp(1'b1, 64'hAAAAAAAA, 1'b0, 1);
        serve(1, 0);

        // simultaneous data read and fetch: data first
        bus_rdata = 64'h01234567_89ABCDEF;
        dm_addr = 64'h2000; dm_rw = 1'b0;
        push_grant(64'h2000, 1'b0, 64'd0, 1);
        push_rsp(1'b0, 64'h01234567_89ABCDEF, 1'b0, 1);
        push_grant(64'h1004, 1'b0, 64'd0, 1);
        push_rsp(1'b1, 64'h01234567, 1'b0, 1);
        serve(1, 1);
        check("dm_before_if_gap", last_if_cyc - last_dm_cyc, 3);

        // continuous contention: D D D D I D D D D I
        bus_rdata = 64'hCAFEF00D_12345678;
        if_addr = 64'h1000;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                push_grant(64'h1000, 1'b0, 64'd0, 1);
                push_rsp(1'b1, 64'h12345678, 1'b0, 1);
            end else begin
                push_grant(64'h2000, 1'b0, 64'd0, 1);
                push_rsp(1'b0, 64'hCAFEF00D_12345678, 1'b0, 1);
            end
        end
        serve(2, 8);

        // write with two wait cycles
        bus_rdata = 64'hFFFF0000_FFFF0000;
        ack_wait = 2;
        dm_addr = 64'h3000; dm_rw = 1'b1; dm_wdata = 64'h11223344_55667788;
        push_grant(64'h3000, 1'b1, 64'h11223344_55667788, 3);
        push_rsp(1'b0, 64'd0, 1'b0, 3);
        serve(0, 1);
        ack_wait = 0;

        // timeout, then a normal request
        no_ack = 1'b1;
        bus_rdata = 64'h55555555_55555555;
        dm_addr = 64'h4000; dm_rw = 1'b0; dm_wdata = 64'd0;
        push_grant(64'h4000, 1'b0, 64'd0, 8);
        push_rsp(1'b0, 64'd0, 1'b1, 8);
        serve(0, 1);
        no_ack = 1'b0;
        bus_rdata = 64'h99999999_77777777;
        if_addr = 64'h1004;
        push_grant(64'h1004, 1'b0, 64'd0, 1);
        push_rsp(1'b1, 64'h99999999, 1'b0, 1);
        serve(1, 0);

        // reset during the second wait cycle of a fetch
        no_ack = 1'b1;
        if_addr = 64'h5000;
        push_grant(64'h5000, 1'b0, 64'd0, 2);
        if_req = 1'b1;
        tick();
        tick();
        check("mid_bus_req", bus_req, 1);
        rst = 1'b1;
        if_req = 1'b0;
        tick();
        check("mid_rst_bus_req", bus_req, 0);
        check("mid_rst_bus_addr", bus_addr, 0);
        check("mid_rst_if_ready", if_ready, 0);
        check("mid_rst_if_data", if_data, 0);
        check("mid_rst_bus_err", bus_err, 0);
        rst = 1'b0;
        no_ack = 1'b0;
        tick();
        bus_rdata = 64'h0BADBEEF_600DCAFE;
        if_addr = 64'h1000;
        push_grant(64'h1000, 1'b0, 64'd0, 1);
        push_rsp(1'b1, 64'h600DCAFE, 1'b0, 1);
        serve(1, 0);

        check("grants_left", gq.size(), 0);
        check("rsps_left", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
